// File: rtl/dadda_mac_if.sv
// Stream bundle between the Dadda multiplier and the MAC accumulator:
// product input handshake, frame abort, and result output handshake.
interface dadda_mac_if #(
  parameter int ACC_W = 10
);
  logic [7:0]       prod_in;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic [7:0]       term_cnt;

  // Producer/consumer side: drives products, abort and result acceptance.
  modport master (
    output prod_in, in_valid, clear, out_ready,
    input  in_ready, acc_out, out_valid, ovf, term_cnt
  );

  // Accumulator side.
  modport slave (
    input  prod_in, in_valid, clear, out_ready,
    output in_ready, acc_out, out_valid, ovf, term_cnt
  );
endinterface

// File: rtl/dadda_mac_accumulator.sv
// Registered MAC stage behind the 4-bit Dadda multiplier: sums N_TERMS
// unsigned 8-bit products per frame and hands the sum out on valid/ready.
module dadda_mac_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input logic            clk,
  input logic            rst_n,
  dadda_mac_if.slave     bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_TERM = 8'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             frame_ovf_q, frame_ovf_d;
  logic [7:0]       term_cnt_q, term_cnt_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             first_term;
  logic             last_term;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;

  // The first product of a frame loads rather than adds, so a stale acc
  // can never leak into a new frame.
  assign first_term = (term_cnt_q == 8'd0);
  assign last_term  = (term_cnt_q == LAST_TERM);
  assign sum        = (first_term ? '0 : {1'b0, acc_q}) + (ACC_W + 1)'(bus.prod_in);
  assign sum_ovf    = (first_term ? 1'b0 : frame_ovf_q) | sum[ACC_W];

  // NOTE: every variable gets its hold value first so no path through the
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    frame_ovf_d = frame_ovf_q;
    term_cnt_d  = term_cnt_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d       = sum[ACC_W-1:0];
          frame_ovf_d = sum_ovf;
          if (last_term) begin
            acc_out_d   = sum[ACC_W-1:0];
            ovf_d       = sum_ovf;
            out_valid_d = 1'b1;
            term_cnt_d  = 8'd0;
            state_d     = DONE;
          end else begin
            term_cnt_d  = term_cnt_q + 8'd1;
          end
        end
      end
      DONE: begin
        // Output accept only reopens the input next cycle; no bypass.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          frame_ovf_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Abort wins over any transfer in flight, including a pending result.
    if (bus.clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      frame_ovf_d = 1'b0;
      term_cnt_d  = 8'd0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      frame_ovf_q <= 1'b0;
      term_cnt_q  <= 8'd0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      frame_ovf_q <= frame_ovf_d;
      term_cnt_q  <= term_cnt_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
  assign bus.term_cnt  = term_cnt_q;

endmodule

// File: tb/tb_dadda_mac_accumulator.sv
// Drives a 10-bit and an 8-bit accumulator with identical product streams
// and checks both against a wide-sum reference held in a scoreboard.
module tb_dadda_mac_accumulator;

  localparam int N = 4;

  typedef struct {
    logic [9:0] acc10;
    logic       ovf10;
    logic [7:0] acc8;
    logic       ovf8;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] prod_in;
  logic       in_valid;
  logic       clear;
  logic       out_ready;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   msum = 0;
  int   mcnt = 0;

  dadda_mac_if #(.ACC_W(10)) bus10 ();
  dadda_mac_if #(.ACC_W(8))  bus8 ();

  assign bus10.prod_in   = prod_in;
  assign bus10.in_valid  = in_valid;
  assign bus10.clear     = clear;
  assign bus10.out_ready = out_ready;
  assign bus8.prod_in    = prod_in;
  assign bus8.in_valid   = in_valid;
  assign bus8.clear      = clear;
  assign bus8.out_ready  = out_ready;

  dadda_mac_accumulator #(.N_TERMS(N), .ACC_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .bus(bus10.slave)
  );
  dadda_mac_accumulator #(.N_TERMS(N), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, wrapped and flagged per result width.
  task automatic push_frame();
    exp_t e;
    e.acc10 = 10'(msum);
    e.ovf10 = (msum > 1023);
    e.acc8  = 8'(msum);
    e.ovf8  = (msum > 255);
    sb.push_back(e);
    msum = 0;
    mcnt = 0;
  endtask

  // Present p (in_valid stays high afterwards) and return one negedge after
  // the edge that accepted it.
  task automatic send(input logic [7:0] p);
    int n = 0;
    prod_in  = p;
    in_valid = 1'b1;
    while (!bus10.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout", 32'(bus10.in_ready), 32'd1);
      return;
    end
    msum += p;
    mcnt++;
    if (mcnt == N) push_frame();
    @(negedge clk);
    check("term_cnt10", 32'(bus10.term_cnt), 32'(mcnt));
    check("term_cnt8", 32'(bus8.term_cnt), 32'(mcnt));
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic collect(input string tag);
    int   n = 0;
    exp_t e;
    while (!bus10.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check({tag, "_out_valid_timeout"}, 32'(bus10.out_valid), 32'd1);
      return;
    end
    check({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_acc10"}, 32'(bus10.acc_out), 32'(e.acc10));
    check({tag, "_ovf10"}, 32'(bus10.ovf), 32'(e.ovf10));
    check({tag, "_acc8"}, 32'(bus8.acc_out), 32'(e.acc8));
    check({tag, "_ovf8"}, 32'(bus8.ovf), 32'(e.ovf8));
    check({tag, "_in_ready_done"}, 32'(bus10.in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(bus10.out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(bus10.in_ready), 32'd1);
    check({tag, "_term_cnt_zero"}, 32'(bus10.term_cnt), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    prod_in   = 8'd0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_in_ready", 32'(bus10.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus10.out_valid), 32'd0);
    check("rst_acc_out", 32'(bus10.acc_out), 32'd0);
    check("rst_ovf", 32'(bus10.ovf), 32'd0);
    check("rst_term_cnt", 32'(bus10.term_cnt), 32'd0);

    // Full-scale frame with in_valid held, then 5 cycles of back-pressure.
    for (int i = 0; i < N; i++) send(8'd225);
    check("t1_out_valid", 32'(bus10.out_valid), 32'd1);
    check("t1_in_ready", 32'(bus10.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_hold_in_ready", 32'(bus10.in_ready), 32'd0);
      check("t1_hold_out_valid", 32'(bus10.out_valid), 32'd1);
      check("t1_hold_acc", 32'(bus10.acc_out), 32'd900);
    end
    collect("t1");

    // Wrap in the narrow instance, then a small clean frame.
    send(8'd200); send(8'd100); send(8'd0); send(8'd0);
    collect("t3a");
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    collect("t3b");

    // Abort mid-frame; the product presented with clear is dropped.
    send(8'd10); send(8'd20);
    prod_in = 8'd30;
    clear   = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    msum = 0;
    mcnt = 0;
    check("t4_term_cnt", 32'(bus10.term_cnt), 32'd0);
    check("t4_out_valid", 32'(bus10.out_valid), 32'd0);
    send(8'd1); send(8'd1); send(8'd1); send(8'd1);
    collect("t4");

    // Abort a pending result even with out_ready high.
    send(8'd5); send(8'd6); send(8'd7); send(8'd8);
    check("t4d_out_valid", 32'(bus10.out_valid), 32'd1);
    in_valid  = 1'b0;
    clear     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    out_ready = 1'b0;
    void'(sb.pop_front());
    check("t4d_discard_valid", 32'(bus10.out_valid), 32'd0);
    check("t4d_discard_ovf8", 32'(bus8.ovf), 32'd0);
    check("t4d_in_ready", 32'(bus10.in_ready), 32'd1);
    idle(2);
    check("t4d_still_idle", 32'(bus10.out_valid), 32'd0);

    // Gapped input, one accept every third cycle.
    send(8'd9);  idle(2);
    send(8'd81); idle(2);
    send(8'd0);  idle(2);
    send(8'd49);
    in_valid = 1'b0;
    check("t5_out_valid", 32'(bus10.out_valid), 32'd1);
    check("t5_acc10", 32'(bus10.acc_out), 32'd139);
    check("t5_acc8", 32'(bus8.acc_out), 32'd139);
    check("t5_ovf8", 32'(bus8.ovf), 32'd0);

    // Asynchronous reset while DONE, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_out_valid", 32'(bus10.out_valid), 32'd0);
    check("t5_arst_in_ready", 32'(bus10.in_ready), 32'd1);
    check("t5_arst_acc_out", 32'(bus10.acc_out), 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    collect("t6");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
